dispatch_sorter: RTL and testbench

//   Parametrised multi-class dispatch stage between the renamer and the issue buffers.
//   - Takes up to IN_WIDTH renamed ops per cycle and routes each op to one of N_CLASSES
//     in-order FIFOs, selected by the op's class field.
//   - Each FIFO accepts up to PUSH_WIDTH ops per cycle.
//   - Acceptance is prefix-ordered, so program order within each class is preserved.
//   - Accepting a terminator op halts dispatch until resume; flush empties all queues.

---
 rtl/dispatch_sorter.sv | 175 +++++++++++++++++
 tb/tb_dispatch_sorter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dispatch_sorter.sv
// dispatch_sorter: routes up to IN_WIDTH renamed ops per cycle into N_CLASSES in-order
// queues selected by each op's class field. Acceptance is a strict prefix of the valid
// slots, so program order within each class is preserved. A terminator op halts dispatch
// until resume; flush empties every queue.
module dispatch_sorter #(
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned OP_W       = 48,
  parameter int unsigned CLASS_LSB  = 45,
  parameter int unsigned CLASS_W    = 3,
  parameter int unsigned N_CLASSES  = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PUSH_WIDTH = 2,
  parameter int unsigned TERM_CLASS = 2,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_WIDTH*OP_W-1:0]   in_ops,
  input  logic [IN_WIDTH-1:0]        in_valid,
  output logic [IN_WIDTH-1:0]        in_used,
  input  logic                       resume,
  input  logic                       flush,
  output logic                       halted,
  output logic [N_CLASSES*OP_W-1:0]  out_ops,
  output logic [N_CLASSES-1:0]       out_valid,
  input  logic [N_CLASSES-1:0]       out_ready,
  output logic [N_CLASSES*CNT_W-1:0] occupancy,
  output logic                       bad_class
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               bad_class_q, bad_class_d;
  logic [CNT_W-1:0]   cnt_q    [N_CLASSES];
  logic [CNT_W-1:0]   cnt_d    [N_CLASSES];
  logic [PTR_W-1:0]   wr_ptr_q [N_CLASSES];
  logic [PTR_W-1:0]   rd_ptr_q [N_CLASSES];
  logic [OP_W-1:0]    mem_q    [N_CLASSES][DEPTH];

  logic [CLASS_W-1:0] slot_cls [IN_WIDTH];
  logic [OP_W-1:0]    slot_op  [IN_WIDTH];
  logic [PTR_W-1:0]   slot_off [IN_WIDTH];
  logic [IN_WIDTH-1:0] used;
  logic               go;
  logic               term_acc;
  logic               found;
  int unsigned        pcnt [N_CLASSES];
  int unsigned        lim  [N_CLASSES];
  logic [N_CLASSES-1:0] pop;

  // Unpack slot ops and their class fields.
  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      slot_op[i]  = in_ops[i*OP_W +: OP_W];
      slot_cls[i] = slot_op[i][CLASS_LSB +: CLASS_W];
    end
  end

  // Prefix acceptance scan: each slot needs all earlier slots used, no earlier terminator,
  // and room in its class under both the push limit and the registered free space.
  always_comb begin
    go       = (state_q == StRun) && !flush && !rst;
    used     = '0;
    term_acc = 1'b0;
    for (int k = 0; k < N_CLASSES; k++) begin
      pcnt[k] = 0;
      lim[k]  = DEPTH - 32'(cnt_q[k]);
      if (PUSH_WIDTH < lim[k]) lim[k] = PUSH_WIDTH;
    end
    for (int i = 0; i < IN_WIDTH; i++) begin
      slot_off[i] = '0;
      if (go && in_valid[i]) begin
        for (int k = 0; k < N_CLASSES; k++) begin
          if (slot_cls[i] == CLASS_W'(k) && pcnt[k] < lim[k]) begin
            used[i]     = 1'b1;
            slot_off[i] = PTR_W'(pcnt[k]);
            pcnt[k]     = pcnt[k] + 1;
          end
        end
      end
      if (!used[i]) begin
        go = 1'b0;
      end else if (slot_cls[i] == CLASS_W'(TERM_CLASS)) begin
        // The terminator is the last slot taken this cycle.
        go       = 1'b0;
        term_acc = 1'b1;
      end
    end
  end

  // Sticky bad-class flag: set when the first unused slot is valid with an out-of-range class.
  always_comb begin
    bad_class_d = bad_class_q;
    found       = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (!found && !used[i]) begin
        found = 1'b1;
        if (in_valid[i] && ({1'b0, slot_cls[i]} >= (CLASS_W + 1)'(N_CLASSES))) begin
          bad_class_d = 1'b1;
        end
      end
    end
  end

  // Queue heads, pops and next-state counts.
  always_comb begin
    for (int k = 0; k < N_CLASSES; k++) begin
      out_valid[k] = (cnt_q[k] != '0);
      pop[k]       = out_valid[k] && out_ready[k] && !flush;
      cnt_d[k]     = cnt_q[k] + CNT_W'(pcnt[k]) - CNT_W'(pop[k]);
      out_ops[k*OP_W +: OP_W]      = out_valid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
      occupancy[k*CNT_W +: CNT_W]  = cnt_q[k];
    end
  end

  // RUN/HALT control; flush wins over resume and over a terminator acceptance.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else if (state_q == StRun && term_acc) begin
      state_d = StHalt;
    end else if (state_q == StHalt && resume) begin
      state_d = StRun;
    end
  end

  // Control state, counts and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      bad_class_q <= 1'b0;
      for (int k = 0; k < N_CLASSES; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bad_class_q <= bad_class_d;
      for (int k = 0; k < N_CLASSES; k++) begin
        if (flush) begin
          cnt_q[k]    <= '0;
          wr_ptr_q[k] <= '0;
          rd_ptr_q[k] <= '0;
        end else begin
          cnt_q[k]    <= cnt_d[k];
          // Pointer width equals log2(DEPTH), so the add wraps naturally.
          wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(pcnt[k]);
          if (pop[k]) rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
        end
      end
    end
  end

  // Queue storage; used ops land at consecutive slots from each class's write pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        if (used[i] && slot_cls[i] == CLASS_W'(k)) begin
          mem_q[k][wr_ptr_q[k] + slot_off[i]] <= slot_op[i];
        end
      end
    end
  end

  assign in_used   = used;
  assign halted    = (state_q == StHalt);
  assign bad_class = bad_class_q;

endmodule

// File: tb/tb_dispatch_sorter.sv
// Scoreboard bench for dispatch_sorter: accepted ops are queued per class when driven and
// compared against out_ops as the consumer pops them.
module tb_dispatch_sorter;
  localparam int IW  = 4;
  localparam int OPW = 48;
  localparam int NC  = 3;
  localparam int CNW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IW*OPW-1:0] in_ops = '0;
  logic [IW-1:0]     in_valid = '0;
  logic [IW-1:0]     in_used;
  logic              resume = 1'b0;
  logic              flush = 1'b0;
  logic              halted;
  logic [NC*OPW-1:0] out_ops;
  logic [NC-1:0]     out_valid;
  logic [NC-1:0]     out_ready = '0;
  logic [NC*CNW-1:0] occupancy;
  logic              bad_class;

  dispatch_sorter dut (
    .clk       (clk),
    .rst       (rst),
    .in_ops    (in_ops),
    .in_valid  (in_valid),
    .in_used   (in_used),
    .resume    (resume),
    .flush     (flush),
    .halted    (halted),
    .out_ops   (out_ops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .bad_class (bad_class)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tag_ctr  = 1;
  logic exp_bad = 1'b0;
  logic [OPW-1:0] sb [NC][$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_used"}, 64'(in_used), 64'd0);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_halted"}, 64'(halted), 64'd0);
    check({pfx, "_occupancy"}, 64'(occupancy), 64'd0);
    check({pfx, "_bad_class"}, 64'(bad_class), 64'd0);
    for (int k = 0; k < NC; k++) check({pfx, "_out_ops"}, out_ops[k*OPW +: OPW], 64'd0);
  endtask

  // One cycle: drive at posedge+1, check in_used and popped heads, then check registered
  // state just after the next edge. cls packs slot i's class at [3i +: 3].
  task automatic run_cycle(input logic [11:0] cls, input logic [3:0] vld, input logic [2:0] rdy,
                           input logic res, input logic fl, input logic [3:0] exp_used,
                           input logic exp_halt);
    logic [OPW-1:0] op [IW];
    for (int i = 0; i < IW; i++) begin
      op[i] = {cls[3*i +: 3], 45'(tag_ctr + i)};
      in_ops[i*OPW +: OPW] = op[i];
    end
    tag_ctr  += IW;
    in_valid  = vld;
    out_ready = rdy;
    resume    = res;
    flush     = fl;
    #1;
    check("in_used", 64'(in_used), 64'(exp_used));
    for (int k = 0; k < NC; k++) begin
      if (!fl && rdy[k] && sb[k].size() > 0) begin
        check($sformatf("head_q%0d", k), out_ops[k*OPW +: OPW], sb[k][0]);
        void'(sb[k].pop_front());
      end
    end
    if (fl) begin
      for (int k = 0; k < NC; k++) sb[k].delete();
    end else begin
      for (int i = 0; i < IW; i++) if (exp_used[i]) sb[int'(cls[3*i +: 3])].push_back(op[i]);
    end
    @(posedge clk);
    #1;
    in_valid  = '0;
    out_ready = '0;
    resume    = 1'b0;
    flush     = 1'b0;
    for (int k = 0; k < NC; k++) begin
      check($sformatf("occ_q%0d", k), 64'(occupancy[k*CNW +: CNW]), 64'(sb[k].size()));
      check($sformatf("valid_q%0d", k), 64'(out_valid[k]), 64'(sb[k].size() > 0));
    end
    check("halted", 64'(halted), 64'(exp_halt));
    check("bad_class", 64'(bad_class), 64'(exp_bad));
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Routing order: two classes interleaved, popped in slot order.
    run_cycle({3'd1, 3'd0, 3'd1, 3'd0}, 4'b1111, 3'b000, 0, 0, 4'b1111, 0);
    run_cycle(12'd0, 4'b0000, 3'b001, 0, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0000, 3'b011, 0, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0000, 3'b010, 0, 0, 4'b0000, 0);

    // Push limit: the third class-0 slot is refused and blocks slot 3.
    run_cycle({3'd1, 3'd0, 3'd0, 3'd0}, 4'b1111, 3'b000, 0, 0, 4'b0011, 0);
    run_cycle(12'd0, 4'b0000, 3'b001, 0, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0000, 3'b001, 0, 0, 4'b0000, 0);

    // Full queue, same-cycle pop does not free space, then wrap rounds.
    run_cycle(12'd0, 4'b0011, 3'b000, 0, 0, 4'b0011, 0);
    run_cycle(12'd0, 4'b0011, 3'b000, 0, 0, 4'b0011, 0);
    run_cycle(12'd0, 4'b0001, 3'b000, 0, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0001, 3'b001, 0, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0001, 3'b000, 0, 0, 4'b0001, 0);
    run_cycle(12'd0, 4'b0001, 3'b001, 0, 0, 4'b0000, 0);
    for (int r = 0; r < 10; r++) run_cycle(12'd0, 4'b0001, 3'b001, 0, 0, 4'b0001, 0);
    for (int r = 0; r < 3; r++) run_cycle(12'd0, 4'b0000, 3'b001, 0, 0, 4'b0000, 0);

    // Terminator halt and resume; resume in RUN is ignored.
    run_cycle({3'd0, 3'd1, 3'd2, 3'd0}, 4'b1111, 3'b000, 0, 0, 4'b0011, 1);
    run_cycle(12'd0, 4'b1111, 3'b000, 0, 0, 4'b0000, 1);
    run_cycle(12'd0, 4'b1111, 3'b000, 1, 0, 4'b0000, 0);
    run_cycle(12'd0, 4'b0011, 3'b000, 1, 0, 4'b0011, 0);

    // Flush priority with queues holding {3,1,2}.
    run_cycle({3'd0, 3'd0, 3'd0, 3'd1}, 4'b0001, 3'b000, 0, 0, 4'b0001, 0);
    run_cycle({3'd0, 3'd0, 3'd0, 3'd2}, 4'b0001, 3'b000, 0, 0, 4'b0001, 1);
    run_cycle(12'd0, 4'b1111, 3'b111, 1, 1, 4'b0000, 0);
    run_cycle(12'd0, 4'b0000, 3'b111, 0, 0, 4'b0000, 0);

    // Bad class in slot 1: sticky across flush.
    exp_bad = 1'b1;
    run_cycle({3'd0, 3'd0, 3'd5, 3'd0}, 4'b0011, 3'b000, 0, 0, 4'b0001, 0);
    run_cycle(12'd0, 4'b0000, 3'b000, 0, 1, 4'b0000, 0);
    run_cycle({3'd0, 3'd0, 3'd1, 3'd2}, 4'b0011, 3'b000, 0, 0, 4'b0001, 1);

    // Async reset mid-stream clears everything without a clock edge.
    in_valid = 4'b1111;
    rst      = 1'b1;
    #1;
    check_all_zero("midrst");
    for (int k = 0; k < NC; k++) sb[k].delete();
    exp_bad = 1'b0;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycle(12'd0, 4'b0001, 3'b000, 0, 0, 4'b0001, 0);
    run_cycle(12'd0, 4'b0000, 3'b001, 0, 0, 4'b0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
